mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 8x8 memory.
// Each access is one IDLE->ACCESS->IDLE round trip: grant pulse, then ack pulse.
module mem_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       we_a,
    input  logic       we_b,
    input  logic [2:0] addr_a,
    input  logic [2:0] addr_b,
    input  logic [7:0] wdata_a,
    input  logic [7:0] wdata_b,
    input  logic [7:0] mem_dout,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b,
    output logic       mem_we,
    output logic [2:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t     state_q, state_d;
    // last_b_q is set at grant time, so during ACCESS it names the current owner.
    logic       last_b_q, last_b_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       ack_a_q, ack_a_d;
    logic       ack_b_q, ack_b_d;
    logic [7:0] rdata_a_q, rdata_a_d;
    logic [7:0] rdata_b_q, rdata_b_d;
    logic       mem_we_q, mem_we_d;
    logic [2:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_din_q, mem_din_d;
    logic       win_b;

    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        win_b      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    // B wins when alone, or on a tie when A was granted last.
                    win_b      = req_b && (!req_a || !last_b_q);
                    state_d    = ACCESS;
                    last_b_d   = win_b;
                    gnt_a_d    = !win_b;
                    gnt_b_d    = win_b;
                    mem_we_d   = win_b ? we_b    : we_a;
                    mem_addr_d = win_b ? addr_b  : addr_a;
                    mem_din_d  = win_b ? wdata_b : wdata_a;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                ack_a_d = !last_b_q;
                ack_b_d = last_b_q;
                if (!mem_we_q) begin
                    if (last_b_q) rdata_b_d = mem_dout;
                    else          rdata_a_d = mem_dout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            rdata_a_q  <= 8'h00;
            rdata_b_q  <= 8'h00;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 3'd0;
            mem_din_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign ack_a    = ack_a_q;
    assign ack_b    = ack_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign busy     = (state_q == ACCESS);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, per-requester stimulus queues,
// transaction-level reference model feeding expected-grant/ack queues.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b, we_a, we_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic [7:0] mem_dout;
    logic       gnt_a, gnt_b, ack_a, ack_b;
    logic [7:0] rdata_a, rdata_b;
    logic       mem_we;
    logic [2:0] mem_addr;
    logic [7:0] mem_din;
    logic       busy;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .mem_dout(mem_dout),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .ack_a(ack_a), .ack_b(ack_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy)
    );

    // External 8x8 memory: write on the edge that samples mem_we, read combinationally.
    logic [7:0] tb_mem   [8];
    logic [7:0] init_val [8];
    logic       mem_init_go;

    always @(posedge clk) begin
        if (mem_init_go) begin
            for (int i = 0; i < 8; i++) tb_mem[i] <= init_val[i];
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_din;
        end
    end
    assign mem_dout = tb_mem[mem_addr];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event did not occur as expected", name);
    endtask

    // Reference model: one transaction in flight; grant entries {cycle, who_b, we, addr, din},
    // ack entries {cycle, who_b, rdata_a, rdata_b}.
    int         cyc = 0;
    bit         m_busy, m_last_b, m_who_b, m_we;
    logic [2:0] m_addr;
    logic [7:0] m_din, m_rd_a, m_rd_b;
    logic [7:0] m_mem [8];
    logic [44:0] exp_gnt_q [$];
    logic [48:0] exp_ack_q [$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_init_go) begin
            for (int i = 0; i < 8; i++) m_mem[i] = init_val[i];
        end
        if (!rst_n) begin
            // An aborted write was still presented to the memory on this edge.
            if (m_busy && m_we) m_mem[m_addr] = m_din;
            m_busy = 1'b0; m_last_b = 1'b1; m_we = 1'b0;
            m_addr = 3'd0; m_din = 8'h00; m_rd_a = 8'h00; m_rd_b = 8'h00;
        end else if (m_busy) begin
            if (m_we)         m_mem[m_addr] = m_din;
            else if (m_who_b) m_rd_b = m_mem[m_addr];
            else              m_rd_a = m_mem[m_addr];
            exp_ack_q.push_back({cyc[31:0], m_who_b, m_rd_a, m_rd_b});
            m_busy = 1'b0;
            m_we   = 1'b0;
        end else if (req_a || req_b) begin
            if (req_a && req_b) m_who_b = !m_last_b;
            else                m_who_b = req_b;
            m_last_b = m_who_b;
            m_we     = m_who_b ? we_b    : we_a;
            m_addr   = m_who_b ? addr_b  : addr_a;
            m_din    = m_who_b ? wdata_b : wdata_a;
            exp_gnt_q.push_back({cyc[31:0], m_who_b, m_we, m_addr, m_din});
            m_busy   = 1'b1;
        end
    end

    // Monitor: compares DUT events against the expected queues, away from the active edge.
    bit          mon_en = 1'b0;
    bit          have_gnt = 1'b0;
    int          last_gnt_cyc = 0;
    logic [44:0] ge;
    logic [48:0] ae;
    bit          grant_log [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt_a || gnt_b) begin
                chk("gnt_exclusive", {30'd0, gnt_a, gnt_b} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
                if (have_gnt) chk("gnt_spacing", (cyc - last_gnt_cyc) >= 2 ? 32'd1 : 32'd0, 32'd1);
                have_gnt = 1'b1;
                last_gnt_cyc = cyc;
                grant_log.push_back(gnt_b);
                if (exp_gnt_q.size() == 0) begin
                    report_fail("gnt_unexpected");
                end else begin
                    ge = exp_gnt_q.pop_front();
                    chk("gnt_cycle", cyc, ge[44:13]);
                    chk("grant", {19'd0, gnt_b, mem_we, mem_addr, mem_din}, {19'd0, ge[12:0]});
                end
            end else if (exp_gnt_q.size() > 0 && int'(exp_gnt_q[0][44:13]) <= cyc) begin
                ge = exp_gnt_q.pop_front();
                report_fail("gnt_missing");
            end
            if (ack_a || ack_b) begin
                chk("ack_exclusive", (ack_a && ack_b) ? 32'd1 : 32'd0, 32'd0);
                if (exp_ack_q.size() == 0) begin
                    report_fail("ack_unexpected");
                end else begin
                    ae = exp_ack_q.pop_front();
                    chk("ack_cycle", cyc, ae[48:17]);
                    chk("ack_rdata", {15'd0, ack_b, rdata_a, rdata_b}, {15'd0, ae[16:0]});
                end
            end else if (exp_ack_q.size() > 0 && int'(exp_ack_q[0][48:17]) <= cyc) begin
                ae = exp_ack_q.pop_front();
                report_fail("ack_missing");
            end
            chk("busy_is_access", {31'd0, busy}, {31'd0, gnt_a | gnt_b});
            chk("mem_we_only_access", {31'd0, mem_we & ~busy}, 32'd0);
        end
    end

    // Stimulus: each requester holds one transaction {we, addr, data} until its grant.
    logic [11:0] qa [$];
    logic [11:0] qb [$];
    bit          rand_gap = 1'b0;

    task automatic tick();
        logic [11:0] t;
        @(negedge clk);
        if (gnt_a) req_a = 1'b0;
        if (gnt_b) req_b = 1'b0;
        if (!req_a && qa.size() > 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
            t = qa.pop_front();
            req_a = 1'b1; we_a = t[11]; addr_a = t[10:8]; wdata_a = t[7:0];
        end
        if (!req_b && qb.size() > 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
            t = qb.pop_front();
            req_b = 1'b1; we_b = t[11]; addr_b = t[10:8]; wdata_b = t[7:0];
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            done = qa.size() == 0 && qb.size() == 0 && !req_a && !req_b && !m_busy &&
                   exp_gnt_q.size() == 0 && exp_ack_q.size() == 0;
            if (done) break;
            tick();
        end
        if (!done) report_fail("wait_idle_timeout");
    endtask

    task automatic chk_reset_vals();
        chk("rst_ctrl", {26'd0, gnt_a, gnt_b, ack_a, ack_b, busy, mem_we}, 32'd0);
        chk("rst_mem_addr", {29'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
        chk("rst_rdata", {16'd0, rdata_a, rdata_b}, 32'd0);
    endtask

    initial begin
        logic [11:0] t;
        bit          seen;
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 3'd0; addr_b = 3'd0; wdata_a = 8'h00; wdata_b = 8'h00;
        for (int i = 0; i < 8; i++) init_val[i] = 8'($urandom_range(0, 255));
        init_val[0] = 8'h3C;
        init_val[7] = 8'hC3;
        mem_init_go = 1'b1;
        tick();
        mem_init_go = 1'b0;
        tick();
        mon_en = 1'b1;
        chk_reset_vals();

        // Simultaneous requests held through reset: A reads 0, B writes 0x11 to 0.
        qa.push_back({1'b0, 3'd0, 8'hA5});
        qb.push_back({1'b1, 3'd0, 8'h11});
        tick();
        tick();
        grant_log.delete();
        rst_n = 1'b1;
        wait_idle(50);
        chk("tie_count", grant_log.size(), 32'd2);
        if (grant_log.size() == 2) begin
            chk("tie_first_a", {31'd0, grant_log[0]}, 32'd0);
            chk("tie_second_b", {31'd0, grant_log[1]}, 32'd1);
        end
        chk("tie_read_old", {24'd0, rdata_a}, 32'h3C);
        qa.push_back({1'b0, 3'd0, 8'h00});
        wait_idle(50);
        chk("read_after_b_write", {24'd0, rdata_a}, 32'h11);

        // A writes 0x5A to 3, then reads it back.
        qa.push_back({1'b1, 3'd3, 8'h5A});
        wait_idle(50);
        qa.push_back({1'b0, 3'd3, 8'h77});
        wait_idle(50);
        chk("a_readback", {24'd0, rdata_a}, 32'h5A);

        // B reads 7 while A writes 2; A's write leaves rdata_a untouched.
        qa.push_back({1'b1, 3'd2, 8'hE7});
        qb.push_back({1'b0, 3'd7, 8'h00});
        wait_idle(50);
        chk("b_read7", {24'd0, rdata_b}, 32'hC3);
        chk("a_rdata_kept", {24'd0, rdata_a}, 32'h5A);

        // Fresh reset, then 8 back-to-back contended grants.
        rst_n = 1'b0;
        tick();
        chk_reset_vals();
        rst_n = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            t = 12'($urandom_range(0, 4095));
            qa.push_back(t);
            t = 12'($urandom_range(0, 4095));
            qb.push_back(t);
        end
        wait_idle(100);
        chk("rr_count", grant_log.size(), 32'd8);
        if (grant_log.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("rr_order", {31'd0, grant_log[i]}, 32'(i % 2));
        end

        // Quiet period: nothing moves.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ctrl", {26'd0, busy, mem_we, gnt_a, gnt_b, ack_a, ack_b}, 32'd0);
            chk("idle_addr", {29'd0, mem_addr}, {29'd0, m_addr});
        end

        // Reset during B's write access aborts it.
        qb.push_back({1'b1, 3'd5, 8'hFF});
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt_b) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) report_fail("abort_gnt_b_timeout");
        rst_n = 1'b0;
        tick();
        chk("abort_no_ack", {31'd0, ack_b}, 32'd0);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk_reset_vals();
        rst_n = 1'b1;
        tick();
        chk("abort_no_late_ack", {30'd0, ack_a, ack_b}, 32'd0);

        // Randomized traffic with random request gaps.
        rand_gap = 1'b1;
        for (int i = 0; i < 160; i++) begin
            t = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 0) qa.push_back(t);
            else                           qb.push_back(t);
        end
        wait_idle(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
